// File: rtl/lemming_pkg.sv
// Shared lemming types: world state encoding and the walker output bundle.
// Used by lemming_world and by the walker benches.
package lemming_pkg;

  typedef enum logic [1:0] {
    WALK = 2'd0,
    FALL = 2'd1,
    DONE = 2'd2
  } lw_state_e;

  typedef struct packed {
    logic walk_left;
    logic walk_right;
    logic aaah;
  } walker_out_t;

  function automatic logic both_dirs(input walker_out_t w);
    return w.walk_left & w.walk_right;
  endfunction

endpackage

// File: rtl/lemming_world_chk.sv
// Sticky walker protocol monitor for the lemming world.
// Standalone so benches can bind it as a monitor.
module lemming_world_chk
  import lemming_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  lw_state_e   state,
  input  logic        footing,
  input  walker_out_t wo,
  output logic        protocol_err
);

  logic viol;

  always_comb begin
    viol = both_dirs(wo);
    if (state == FALL && (wo.walk_left || wo.walk_right))
      viol = 1'b1;
    if (state == WALK && footing && wo.aaah)
      viol = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset)
      protocol_err <= 1'b0;
    else if (viol)
      protocol_err <= 1'b1;
  end

endmodule

// File: rtl/lemming_world.sv
// Terrain/position model closing the loop around the lemming walker.
// Define LEMMING_WORLD_PITFILL_EN to fill pits on landing (adds pits_filled).
module lemming_world
  import lemming_pkg::*;
#(
  parameter int TRACK_LEN   = 16,
  parameter int START_POS   = 1,
  parameter int EXIT_POS    = 14,
  parameter int FALL_CYCLES = 3
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [TRACK_LEN-1:0]         terrain_init,
  input  logic                         walk_left,
  input  logic                         walk_right,
  input  logic                         aaah,
  output logic                         ground,
  output logic                         bump_left,
  output logic                         bump_right,
  output logic [$clog2(TRACK_LEN)-1:0] pos,
  output logic                         done,
  output logic                         protocol_err
`ifdef LEMMING_WORLD_PITFILL_EN
  ,
  output logic [$clog2(TRACK_LEN+1)-1:0] pits_filled
`endif
);

  localparam int PW = $clog2(TRACK_LEN);
  localparam int CW = $clog2(FALL_CYCLES + 1);

  lw_state_e            state;
  logic [TRACK_LEN-1:0] terrain_q;
  logic [CW-1:0]        fall_cnt;
  logic [CW-1:0]        fall_cnt_nxt;
  logic                 landed_q;
  logic                 footing;
  logic                 walking;
  logic                 at_left;
  logic                 at_right;
  logic                 move_l;
  logic                 move_r;
  logic                 land;
  logic [PW-1:0]        pos_nxt;
  walker_out_t          wo;

  assign footing  = terrain_q[pos] | landed_q;
  assign walking  = (state == WALK);
  assign at_left  = (pos == '0);
  assign at_right = (pos == PW'(TRACK_LEN - 1));

  assign ground     = (walking & footing) | (state == DONE);
  assign bump_left  = walking & footing & walk_left & at_left;
  assign bump_right = walking & footing & walk_right & at_right;
  assign done       = (state == DONE);

  assign move_l = walk_left & ~walk_right & ~at_left;
  assign move_r = walk_right & ~walk_left & ~at_right;

  always_comb begin
    pos_nxt = pos;
    if (move_l)
      pos_nxt = pos - 1'b1;
    else if (move_r)
      pos_nxt = pos + 1'b1;
  end

  // Landing when the incremented count reaches FALL_CYCLES-1 gives exactly
  // FALL_CYCLES ground-low cycles, counting the WALK cycle that found the pit.
  assign fall_cnt_nxt = fall_cnt + 1'b1;
  assign land         = int'(fall_cnt_nxt) >= FALL_CYCLES - 1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= WALK;
      terrain_q <= terrain_init;
      pos       <= PW'(START_POS);
      fall_cnt  <= '0;
      landed_q  <= 1'b0;
`ifdef LEMMING_WORLD_PITFILL_EN
      pits_filled <= '0;
`endif
    end else begin
      unique case (state)
        WALK: begin
          if (!footing) begin
            state    <= FALL;
            fall_cnt <= '0;
          end else begin
            if (move_l || move_r) begin
              pos      <= pos_nxt;
              landed_q <= 1'b0;
            end
            if (pos_nxt == PW'(EXIT_POS) && terrain_q[EXIT_POS])
              state <= DONE;
          end
        end
        FALL: begin
          fall_cnt <= fall_cnt_nxt;
          if (land) begin
            state    <= WALK;
            landed_q <= 1'b1;
`ifdef LEMMING_WORLD_PITFILL_EN
            terrain_q[pos] <= 1'b1;
            if (pits_filled != ($clog2(TRACK_LEN+1))'(TRACK_LEN))
              pits_filled <= pits_filled + 1'b1;
`endif
          end
        end
        DONE: ;
        default: state <= WALK;
      endcase
    end
  end

  assign wo = '{walk_left: walk_left, walk_right: walk_right, aaah: aaah};

  lemming_world_chk u_chk (
    .clk          (clk),
    .reset        (reset),
    .state        (state),
    .footing      (footing),
    .wo           (wo),
    .protocol_err (protocol_err)
  );

endmodule

// File: tb/tb_lemming_world.sv
// Directed bench for lemming_world: walls, exit, pits, protocol errors, reset.
// Build with LEMMING_WORLD_PITFILL_EN to exercise pit filling.
module tb_lemming_world;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] terrain_init;
  logic        walk_left;
  logic        walk_right;
  logic        aaah;
  logic        ground;
  logic        bump_left;
  logic        bump_right;
  logic [3:0]  pos;
  logic        done;
  logic        protocol_err;
`ifdef LEMMING_WORLD_PITFILL_EN
  logic [4:0]  pits_filled;
`endif

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  lemming_world dut (
    .clk          (clk),
    .reset        (reset),
    .terrain_init (terrain_init),
    .walk_left    (walk_left),
    .walk_right   (walk_right),
    .aaah         (aaah),
    .ground       (ground),
    .bump_left    (bump_left),
    .bump_right   (bump_right),
    .pos          (pos),
    .done         (done),
    .protocol_err (protocol_err)
`ifdef LEMMING_WORLD_PITFILL_EN
    ,
    .pits_filled  (pits_filled)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic l, input logic r);
    walk_left  = l;
    walk_right = r;
  endtask

  task automatic do_reset(input logic [15:0] t);
    terrain_init = t;
    drive(1'b0, 1'b0);
    aaah  = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(16'hFFFF);
    checks++;
    if (pos !== 4'd1) begin
      $display("FAIL reset_pos got %0d want 1", pos); fails++;
    end
    checks++;
    if (ground !== 1'b1 || done !== 1'b0 || protocol_err !== 1'b0) begin
      $display("FAIL reset_flags got g=%b d=%b e=%b want 1 0 0",
               ground, done, protocol_err);
      fails++;
    end
    checks++;
    if (bump_left !== 1'b0 || bump_right !== 1'b0) begin
      $display("FAIL reset_bumps got %b%b want 00", bump_left, bump_right);
      fails++;
    end
  endtask

  task automatic test_flat_walk();
    do_reset(16'hFFFF);
    drive(1'b1, 1'b0);
    tick();
    checks++;
    if (pos !== 4'd0 || bump_left !== 1'b1) begin
      $display("FAIL flat_left_wall got pos=%0d bl=%b want 0 1",
               pos, bump_left);
      fails++;
    end
    tick();
    checks++;
    if (pos !== 4'd0) begin
      $display("FAIL flat_wall_hold got %0d want 0", pos); fails++;
    end
    drive(1'b0, 1'b1);
    for (int i = 0; i < 14; i++) tick();
    checks++;
    if (pos !== 4'd14 || done !== 1'b1) begin
      $display("FAIL flat_exit got pos=%0d done=%b want 14 1", pos, done);
      fails++;
    end
    tick();
    tick();
    checks++;
    if (pos !== 4'd14 || done !== 1'b1 || ground !== 1'b1
        || bump_right !== 1'b0) begin
      $display("FAIL flat_done_frozen got pos=%0d d=%b g=%b br=%b want 14 1 1 0",
               pos, done, ground, bump_right);
      fails++;
    end
    checks++;
    if (protocol_err !== 1'b0) begin
      $display("FAIL flat_no_err got %b want 0", protocol_err); fails++;
    end
  endtask

  task automatic test_pit();
    int n;
    do_reset(16'hFFF7);
    drive(1'b0, 1'b1);
    tick();
    tick();
    checks++;
    if (pos !== 4'd3 || ground !== 1'b0) begin
      $display("FAIL pit_enter got pos=%0d g=%b want 3 0", pos, ground);
      fails++;
    end
    drive(1'b0, 1'b0);
    n = 0;
    while (ground === 1'b0 && n < 10) begin
      n++;
      tick();
    end
    checks++;
    if (n !== 3 || pos !== 4'd3) begin
      $display("FAIL pit_fall_len got n=%0d pos=%0d want 3 3", n, pos);
      fails++;
    end
    drive(1'b0, 1'b1);
    tick();
    checks++;
    if (pos !== 4'd4 || ground !== 1'b1) begin
      $display("FAIL pit_resume got pos=%0d g=%b want 4 1", pos, ground);
      fails++;
    end
    drive(1'b1, 1'b0);
    tick();
    drive(1'b0, 1'b0);
`ifdef LEMMING_WORLD_PITFILL_EN
    checks++;
    if (pos !== 4'd3 || ground !== 1'b1 || pits_filled !== 5'd1) begin
      $display("FAIL pit_refill got pos=%0d g=%b pf=%0d want 3 1 1",
               pos, ground, pits_filled);
      fails++;
    end
`else
    n = 0;
    while (ground === 1'b0 && n < 10) begin
      n++;
      tick();
    end
    checks++;
    if (n !== 3 || pos !== 4'd3) begin
      $display("FAIL pit_refall got n=%0d pos=%0d want 3 3", n, pos);
      fails++;
    end
`endif
    checks++;
    if (protocol_err !== 1'b0) begin
      $display("FAIL pit_no_err got %b want 0", protocol_err); fails++;
    end
  endtask

  task automatic test_right_wall();
    int n;
    do_reset(16'hBFFF);
    drive(1'b0, 1'b1);
    for (int i = 0; i < 13; i++) tick();
    checks++;
    if (pos !== 4'd14 || ground !== 1'b0 || done !== 1'b0) begin
      $display("FAIL rw_pit14 got pos=%0d g=%b d=%b want 14 0 0",
               pos, ground, done);
      fails++;
    end
    drive(1'b0, 1'b0);
    n = 0;
    while (ground === 1'b0 && n < 10) begin
      n++;
      tick();
    end
    drive(1'b0, 1'b1);
    tick();
    checks++;
    if (pos !== 4'd15 || bump_right !== 1'b1) begin
      $display("FAIL rw_bump got pos=%0d br=%b want 15 1", pos, bump_right);
      fails++;
    end
    tick();
    checks++;
    if (pos !== 4'd15 || done !== 1'b0) begin
      $display("FAIL rw_hold got pos=%0d d=%b want 15 0", pos, done);
      fails++;
    end
    drive(1'b0, 1'b0);
  endtask

  task automatic test_both_dirs();
    do_reset(16'hFFFF);
    drive(1'b1, 1'b1);
    tick();
    drive(1'b0, 1'b0);
    checks++;
    if (pos !== 4'd1 || protocol_err !== 1'b1) begin
      $display("FAIL both_dirs got pos=%0d e=%b want 1 1", pos, protocol_err);
      fails++;
    end
    tick();
    tick();
    checks++;
    if (protocol_err !== 1'b1 || pos !== 4'd1) begin
      $display("FAIL both_sticky got e=%b pos=%0d want 1 1",
               protocol_err, pos);
      fails++;
    end
  endtask

  task automatic test_aaah_err();
    do_reset(16'hFFFF);
    aaah = 1'b1;
    tick();
    aaah = 1'b0;
    checks++;
    if (protocol_err !== 1'b1) begin
      $display("FAIL aaah_err got %b want 1", protocol_err); fails++;
    end
  endtask

  task automatic test_reset_mid_fall();
    do_reset(16'hFFFD);
    checks++;
    if (ground !== 1'b0 || pos !== 4'd1) begin
      $display("FAIL start_pit got g=%b pos=%0d want 0 1", ground, pos);
      fails++;
    end
    tick();
    drive(1'b1, 1'b0);
    tick();
    drive(1'b0, 1'b0);
    checks++;
    if (protocol_err !== 1'b1 || ground !== 1'b0) begin
      $display("FAIL fall_walk_err got e=%b g=%b want 1 0",
               protocol_err, ground);
      fails++;
    end
    terrain_init = 16'hFFFF;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (pos !== 4'd1 || ground !== 1'b1 || done !== 1'b0
        || protocol_err !== 1'b0) begin
      $display("FAIL mid_fall_reset got pos=%0d g=%b d=%b e=%b want 1 1 0 0",
               pos, ground, done, protocol_err);
      fails++;
    end
  endtask

  initial begin
    reset        = 1'b1;
    terrain_init = 16'hFFFF;
    walk_left    = 1'b0;
    walk_right   = 1'b0;
    aaah         = 1'b0;
    test_reset();
    test_flat_walk();
    test_pit();
    test_right_wall();
    test_both_dirs();
    test_aaah_err();
    test_reset_mid_fall();
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
